// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch sequencer: holds the PC, handshakes
// fetches with instruction memory, and redirects on branch/JAL/JALR.
module pc_fetch_unit #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_out,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            stall,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc_out,
  output logic            flush,
  output logic            misalign_err,
  output logic [XLEN-1:0] err_addr
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FLUSH,
    HALT
  } state_t;

  state_t          state, state_d;
  logic [XLEN-1:0] pc, pc_d, pc_out_d, err_addr_d;
  logic [XLEN-1:0] jalr_sum, target;
  logic            redirect, instr_valid_d, misalign_d;

  assign jalr_sum = rs1_val + imm;
  assign redirect = jalr | jump | branch_out;

  always_comb begin
    target = ex_pc + imm;
    if (jalr) target = {jalr_sum[XLEN-1:1], 1'b0};
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign flush     = (state == FLUSH);

  always_comb begin
    state_d       = state;
    pc_d          = pc;
    pc_out_d      = pc_out;
    instr_valid_d = 1'b0;
    misalign_d    = misalign_err;
    err_addr_d    = err_addr;
    case (state)
      IDLE:  state_d = FETCH;
      FETCH: begin
        // Redirect wins over a completing transfer; the pending fetch is dropped.
        if (redirect) begin
          if (target[1:0] == 2'b00) begin
            pc_d    = target;
            state_d = FLUSH;
          end else begin
            state_d    = HALT;
            misalign_d = 1'b1;
            err_addr_d = target;
          end
        end else if (imem_ready && !stall) begin
          pc_out_d      = pc;
          pc_d          = pc + XLEN'(4);
          instr_valid_d = 1'b1;
        end
      end
      FLUSH:   state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      pc_out       <= '0;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      err_addr     <= '0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      pc_out       <= pc_out_d;
      instr_valid  <= instr_valid_d;
      misalign_err <= misalign_d;
      err_addr     <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized
// run checked against a cycle-level behavioural model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        branch_out = 1'b0, jump = 1'b0, jalr = 1'b0;
  logic [31:0] ex_pc = '0, imm = '0, rs1_val = '0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        instr_valid;
  logic [31:0] pc_out;
  logic        flush;
  logic        misalign_err;
  logic [31:0] err_addr;

  int total = 0;
  int bad   = 0;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .branch_out(branch_out), .jump(jump), .jalr(jalr),
    .ex_pc(ex_pc), .imm(imm), .rs1_val(rs1_val), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .instr_valid(instr_valid), .pc_out(pc_out), .flush(flush),
    .misalign_err(misalign_err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase flags instead of a state variable.
  logic        m_started, m_bubble, m_halted, m_valid, m_err;
  logic [31:0] m_pc, m_pc_out, m_err_addr;

  task automatic model_reset();
    m_started = 0; m_bubble = 0; m_halted = 0; m_valid = 0; m_err = 0;
    m_pc = 32'h0; m_pc_out = 32'h0; m_err_addr = 32'h0;
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    logic [32:0] wide;
    m_valid = 0;
    if (!m_started) m_started = 1;
    else if (m_halted) m_halted = 1;
    else if (m_bubble) m_bubble = 0;
    else if (jalr || jump || branch_out) begin
      if (jalr) begin
        wide = {1'b0, rs1_val} + {1'b0, imm};
        tgt = wide[31:0];
        if (tgt % 2 == 1) tgt = tgt - 1;
      end else begin
        wide = {1'b0, ex_pc} + {1'b0, imm};
        tgt = wide[31:0];
      end
      if (tgt % 4 == 0) begin
        m_pc = tgt; m_bubble = 1;
      end else begin
        m_halted = 1; m_err = 1; m_err_addr = tgt;
      end
    end else if (imem_ready && !stall) begin
      m_pc_out = m_pc;
      wide = {1'b0, m_pc} + 33'd4;
      m_pc = wide[31:0];
      m_valid = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    branch_out = 0; jump = 0; jalr = 0; stall = 0;
  endtask

  task automatic test_reset();
    reset = 1; imem_ready = 1; clear_ctl();
    #12;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL rst_flush: got %b expected 0", flush); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b expected 0", misalign_err); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL rst_pc_out: got %h expected 0", pc_out); end
    total++; if (err_addr !== 32'h0) begin bad++; $display("FAIL rst_err_addr: got %h expected 0", err_addr); end
    reset = 0;
    tick();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rel_req: got %b expected 1", imem_req); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr;
    for (int i = 0; i < 4; i++) begin
      exp_addr = 32'(4 * i);
      total++; if (imem_addr !== exp_addr) begin bad++; $display("FAIL stream_addr: got %h expected %h", imem_addr, exp_addr); end
      total++; if (instr_valid !== (i > 0)) begin bad++; $display("FAIL stream_valid: got %b expected %b", instr_valid, (i > 0)); end
      if (i > 0) begin
        total++; if (pc_out !== exp_addr - 32'd4) begin bad++; $display("FAIL stream_pc_out: got %h expected %h", pc_out, exp_addr - 32'd4); end
      end
      tick();
    end
  endtask

  task automatic test_wait();
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL wait_req: got %b expected 1", imem_req); end
      total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL wait_addr: got %h expected 10", imem_addr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL wait_valid: got %b expected 0", instr_valid); end
    end
    imem_ready = 1;
    tick();
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL wait_done_valid: got %b expected 1", instr_valid); end
    total++; if (pc_out !== 32'h10) begin bad++; $display("FAIL wait_pc_out: got %h expected 10", pc_out); end
  endtask

  task automatic test_branch();
    branch_out = 1; ex_pc = 32'h20; imm = 32'hFFFF_FFF0;
    tick();
    clear_ctl();
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL br_flush: got %b expected 1", flush); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL br_req: got %b expected 0", imem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL br_valid: got %b expected 0", instr_valid); end
    tick();
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL br_flush_end: got %b expected 0", flush); end
    total++; if (imem_addr !== 32'h10) begin bad++; $display("FAIL br_addr: got %h expected 10", imem_addr); end
    tick();
    total++; if (pc_out !== 32'h10) begin bad++; $display("FAIL br_pc_out: got %h expected 10", pc_out); end
  endtask

  task automatic test_jalr_priority();
    jalr = 1; branch_out = 1; ex_pc = 32'h80; rs1_val = 32'h101; imm = 32'h3;
    tick();
    clear_ctl();
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL jalr_flush: got %b expected 1", flush); end
    // Controls and stall presented during the bubble must be ignored.
    stall = 1; jump = 1; ex_pc = 32'h200; imm = 32'h2;
    tick();
    clear_ctl();
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL jalr_req: got %b expected 1", imem_req); end
    total++; if (imem_addr !== 32'h104) begin bad++; $display("FAIL jalr_addr: got %h expected 104", imem_addr); end
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL jalr_no_err: got %b expected 0", misalign_err); end
    tick();
    total++; if (pc_out !== 32'h104) begin bad++; $display("FAIL jalr_pc_out: got %h expected 104", pc_out); end
  endtask

  task automatic test_wrap_stall();
    jalr = 1; stall = 1; rs1_val = 32'hFFFF_FFFC; imm = 32'h0;
    tick();
    clear_ctl();
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL stall_redirect_flush: got %b expected 1", flush); end
    tick();
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr_top: got %h expected fffffffc", imem_addr); end
    tick();
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr_zero: got %h expected 0", imem_addr); end
    total++; if (pc_out !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc_out: got %h expected fffffffc", pc_out); end
  endtask

  task automatic test_misalign();
    jump = 1; ex_pc = 32'h40; imm = 32'h2;
    tick();
    clear_ctl();
    total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_err: got %b expected 1", misalign_err); end
    total++; if (err_addr !== 32'h42) begin bad++; $display("FAIL mis_err_addr: got %h expected 42", err_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mis_req_held: got %b expected 0", imem_req); end
      total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_err_held: got %b expected 1", misalign_err); end
    end
    reset = 1;
    #2;
    total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL mis_rst_err: got %b expected 0", misalign_err); end
    total++; if (err_addr !== 32'h0) begin bad++; $display("FAIL mis_rst_err_addr: got %h expected 0", err_addr); end
    reset = 0;
    tick();
    total++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin bad++; $display("FAIL mis_restart: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
  endtask

  task automatic test_random();
    int halt_cycles = 0;
    int r;
    reset = 1; clear_ctl(); #2; reset = 0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      r = int'($urandom_range(0, 99));
      stall      = ($urandom_range(0, 3) == 0);
      imem_ready = ($urandom_range(0, 3) != 0);
      jalr       = (r < 4);
      jump       = (r >= 4 && r < 8);
      branch_out = (r >= 6 && r < 12);
      ex_pc      = $urandom & 32'hFFFF_FFFC;
      rs1_val    = $urandom;
      imm        = ($urandom_range(0, 4) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      tick();
      model_edge();
      total++; if (imem_req !== (m_started && !m_bubble && !m_halted)) begin bad++; $display("FAIL rnd_req c=%0d: got %b expected %b", c, imem_req, (m_started && !m_bubble && !m_halted)); end
      total++; if (imem_addr !== m_pc) begin bad++; $display("FAIL rnd_addr c=%0d: got %h expected %h", c, imem_addr, m_pc); end
      total++; if (instr_valid !== m_valid) begin bad++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, instr_valid, m_valid); end
      total++; if (pc_out !== m_pc_out) begin bad++; $display("FAIL rnd_pc_out c=%0d: got %h expected %h", c, pc_out, m_pc_out); end
      total++; if (flush !== m_bubble) begin bad++; $display("FAIL rnd_flush c=%0d: got %b expected %b", c, flush, m_bubble); end
      total++; if (misalign_err !== m_err) begin bad++; $display("FAIL rnd_err c=%0d: got %b expected %b", c, misalign_err, m_err); end
      total++; if (err_addr !== m_err_addr) begin bad++; $display("FAIL rnd_err_addr c=%0d: got %h expected %h", c, err_addr, m_err_addr); end
      halt_cycles = m_halted ? halt_cycles + 1 : 0;
      if (halt_cycles > 4 || $urandom_range(0, 59) == 0) begin
        halt_cycles = 0;
        reset = 1;
        #2;
        total++; if (imem_req !== 1'b0 || flush !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b0) begin bad++; $display("FAIL rnd_async_rst: got req=%b flush=%b valid=%b err=%b expected all 0", imem_req, flush, instr_valid, misalign_err); end
        total++; if (imem_addr !== 32'h0 || pc_out !== 32'h0 || err_addr !== 32'h0) begin bad++; $display("FAIL rnd_async_rst_regs: got addr=%h pc_out=%h err_addr=%h expected 0", imem_addr, pc_out, err_addr); end
        #1;
        reset = 0;
        model_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_branch();
    test_jalr_priority();
    test_wrap_stall();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
